// File: rtl/pla_bist_pkg.sv
// Shared types and polynomial constants for the PLA BIST engine.
package pla_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  // Stimulus LFSR: x^56 + x^55 + x^35 + x^34 + 1
  localparam int LFSR_W    = 56;
  localparam int LFSR_TAP0 = 56;
  localparam int LFSR_TAP1 = 55;
  localparam int LFSR_TAP2 = 35;
  localparam int LFSR_TAP3 = 34;

  // Response MISR: x^23 + x^18 + 1
  localparam int MISR_W    = 23;
  localparam int MISR_TAP0 = 23;
  localparam int MISR_TAP1 = 18;

  // One-hot bit for a 1-based tap position.
  function automatic logic [63:0] tap_bit(input int pos);
    return 64'd1 << (pos - 1);
  endfunction

  localparam logic [LFSR_W-1:0] LFSR_MASK =
    LFSR_W'(tap_bit(LFSR_TAP0) | tap_bit(LFSR_TAP1) | tap_bit(LFSR_TAP2) | tap_bit(LFSR_TAP3));
  localparam logic [MISR_W-1:0] MISR_MASK =
    MISR_W'(tap_bit(MISR_TAP0) | tap_bit(MISR_TAP1));

  // Substituted for an all-zero seed so the LFSR cannot lock up.
  localparam logic [LFSR_W-1:0] SEED_ONES = '1;

endpackage

// File: rtl/pla_bist_engine_if.sv
// Control/status bundle between a test controller and the BIST engine.
interface pla_bist_engine_if
  import pla_bist_pkg::*;
#(
  parameter int IN_W  = LFSR_W,
  parameter int OUT_W = MISR_W,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] pattern_count;
  logic [IN_W-1:0]  seed;
  logic [OUT_W-1:0] golden;
  logic             busy;
  logic             done;
  logic             pass;
  logic [OUT_W-1:0] signature;

  modport master (
    output start, pattern_count, seed, golden,
    input  busy, done, pass, signature
  );

  modport slave (
    input  start, pattern_count, seed, golden,
    output busy, done, pass, signature
  );
endinterface

// File: rtl/pla_bist_lfsr.sv
// Fibonacci-style shift register with load, enable and parallel XOR input.
// Used as the stimulus LFSR (par_in tied low) and as the response MISR.
module pla_bist_lfsr #(
  parameter int           W    = 8,
  parameter logic [W-1:0] TAPS = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] par_in,
  output logic [W-1:0] q,
  output logic [W-1:0] q_nxt
);
  logic [W-1:0] shift_v;

  assign shift_v = {q[W-2:0], ^(q & TAPS)} ^ par_in;

  // Next value: load wins over shift, otherwise hold.
  always_comb begin
    q_nxt = q;
    if (load)    q_nxt = load_val;
    else if (en) q_nxt = shift_v;
  end

  // Register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q_nxt;
  end
endmodule

// File: rtl/pla_bist_engine.sv
// BIST engine for two-level PLA blocks: LFSR stimulus, MISR compaction,
// golden-signature compare. Optional PLA_BIST_ABORT_EN adds an abort input.
//
//  state | meaning
//  IDLE  | reset state, pla_x quiet, waiting for start
//  RUN   | one pattern applied per cycle, remaining counts down
//  DRAIN | RESP_LAT cycles collecting in-flight responses
//  DONE  | signature held, pass compared every cycle
module pla_bist_engine
  import pla_bist_pkg::*;
#(
  parameter int IN_W     = 56,
  parameter int OUT_W    = 23,
  parameter int CNT_W    = 16,
  parameter int RESP_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PLA_BIST_ABORT_EN
  input  logic             abort,
`endif
  pla_bist_engine_if.slave ctl,
  output logic [IN_W-1:0]  pla_x,
  input  logic [OUT_W-1:0] pla_z
);
  bist_state_t      state_q, state_d;
  logic [CNT_W-1:0] remaining_q;
  logic [IN_W-1:0]  lfsr_q, lfsr_nxt, seed_eff;
  logic [OUT_W-1:0] misr_q, misr_nxt;
  logic             start_load, in_run, in_busy, last_cnt, abort_act, cap;
  logic             busy_q, done_q, pass_q;

  assign in_run   = (state_q == RUN);
  assign in_busy  = in_run || (state_q == DRAIN);
  assign last_cnt = (remaining_q == CNT_W'(1));
  assign seed_eff = (ctl.seed == '0) ? SEED_ONES[IN_W-1:0] : ctl.seed;

`ifdef PLA_BIST_ABORT_EN
  assign abort_act = abort && in_busy;
`else
  assign abort_act = 1'b0;
`endif

  // Next-state decode; abort overrides any RUN/DRAIN transition.
  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (ctl.start) begin
          start_load = 1'b1;
          state_d    = (ctl.pattern_count == '0) ? DONE : RUN;
        end
      end
      RUN:     if (last_cnt) state_d = (RESP_LAT == 0) ? DONE : DRAIN;
      DRAIN:   if (last_cnt) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort_act) state_d = IDLE;
  end

  // State register and pattern/drain counter (reloaded with RESP_LAT for DRAIN).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_load)              remaining_q <= ctl.pattern_count;
      else if (in_run && last_cnt) remaining_q <= CNT_W'(RESP_LAT);
      else if (in_busy)            remaining_q <= remaining_q - CNT_W'(1);
    end
  end

  pla_bist_lfsr #(.W(IN_W), .TAPS(LFSR_MASK[IN_W-1:0])) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_load),
    .load_val (seed_eff),
    .en       (in_run),
    .par_in   ({IN_W{1'b0}}),
    .q        (lfsr_q),
    .q_nxt    (lfsr_nxt)
  );

  pla_bist_lfsr #(.W(OUT_W), .TAPS(MISR_MASK[OUT_W-1:0])) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_load || abort_act),
    .load_val ({OUT_W{1'b0}}),
    .en       (cap),
    .par_in   (pla_z),
    .q        (misr_q),
    .q_nxt    (misr_nxt)
  );

  generate
    if (RESP_LAT == 0) begin : g_nolat
      assign cap = in_run;
    end else begin : g_lat
      logic [RESP_LAT-1:0] vsr_q;
      logic [RESP_LAT:0]   vsr_shift;
      assign vsr_shift = {vsr_q, in_run};
      assign cap       = in_busy && vsr_shift[RESP_LAT];
      // Issue-valid shifter: 1 per issued pattern, cleared whenever not busy.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     vsr_q <= '0;
        else if (abort_act || !in_busy) vsr_q <= '0;
        else                            vsr_q <= vsr_shift[RESP_LAT-1:0];
      end
    end
  endgenerate

  // Registered outputs, computed from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pla_x  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      pla_x  <= (state_d == RUN) ? lfsr_nxt : '0;
      busy_q <= (state_d == RUN) || (state_d == DRAIN);
      done_q <= (state_d == DONE);
      pass_q <= (state_d == DONE) && (misr_nxt == ctl.golden);
    end
  end

  assign ctl.busy      = busy_q;
  assign ctl.done      = done_q;
  assign ctl.pass      = pass_q;
  assign ctl.signature = misr_q;

  logic unused_lfsr_q;
  assign unused_lfsr_q = ^lfsr_q;
endmodule

// File: tb/tb_pla_bist_engine.sv
// Directed bench for pla_bist_engine: a combinational-PLA instance (RESP_LAT=0)
// and a 2-stage registered-PLA instance (RESP_LAT=2) sharing clock and reset.
module tb_pla_bist_engine;
  logic clk;
  logic rst_n;
  logic tie_one;
  logic abort;

  int errors = 0;
  int checks = 0;

  pla_bist_engine_if if_c ();
  pla_bist_engine_if if_r ();

  logic [55:0] x_c, x_r;
  logic [22:0] z_c, z_r;
  logic [22:0] z1_r = '0;
  logic [22:0] z2_r = '0;

  // Stand-in two-level PLA response.
  function automatic logic [22:0] pla_f(input logic [55:0] x);
    return x[22:0] ^ x[55:33] ^ (x[45:23] & ~x[33:11]);
  endfunction

  assign z_c = tie_one ? 23'h000001 : pla_f(x_c);

  always @(posedge clk) begin
    z1_r <= pla_f(x_r);
    z2_r <= z1_r;
  end
  assign z_r = z2_r;

  pla_bist_engine #(.RESP_LAT(0)) u_dut_c (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef PLA_BIST_ABORT_EN
    .abort (abort),
`endif
    .ctl   (if_c),
    .pla_x (x_c),
    .pla_z (z_c)
  );

  pla_bist_engine #(.RESP_LAT(2)) u_dut_r (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef PLA_BIST_ABORT_EN
    .abort (1'b0),
`endif
    .ctl   (if_r),
    .pla_x (x_r),
    .pla_z (z_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference signature from the LFSR/MISR equations.
  function automatic logic [22:0] model_sig(input logic [55:0] seed, input int n);
    logic [55:0] l;
    logic [22:0] m;
    l = (seed == '0) ? '1 : seed;
    m = '0;
    for (int i = 0; i < n; i++) begin
      m = {m[21:0], m[22] ^ m[17]} ^ pla_f(l);
      l = {l[54:0], l[55] ^ l[54] ^ l[34] ^ l[33]};
    end
    return m;
  endfunction

  initial begin
    logic [55:0] seed5, seed6;
    logic [22:0] exp5, exp6;
    int dc, dr, bc, br;

    rst_n = 1'b0; tie_one = 1'b0; abort = 1'b0;
    if_c.start = 1'b0; if_c.pattern_count = '0; if_c.seed = '0; if_c.golden = '0;
    if_r.start = 1'b0; if_r.pattern_count = '0; if_r.seed = '0; if_r.golden = '0;
    repeat (2) tick();
    chk("rst_busy", {63'd0, if_c.busy}, 64'd0);
    chk("rst_done", {63'd0, if_c.done}, 64'd0);
    chk("rst_pass", {63'd0, if_c.pass}, 64'd0);
    chk("rst_sig",  {41'd0, if_c.signature}, 64'd0);
    chk("rst_x",    {8'd0, x_c}, 64'd0);
    rst_n = 1'b1;
    tick();

    // seed 1, one pattern, z tied to 1
    tie_one = 1'b1;
    if_c.seed = 56'h1; if_c.pattern_count = 16'd1; if_c.golden = 23'h000001;
    if_c.start = 1'b1; tick(); if_c.start = 1'b0;
    chk("t1_busy", {63'd0, if_c.busy}, 64'd1);
    chk("t1_x",    {8'd0, x_c}, 64'h1);
    chk("t1_done_early", {63'd0, if_c.done}, 64'd0);
    tick();
    chk("t1_done", {63'd0, if_c.done}, 64'd1);
    chk("t1_sig",  {41'd0, if_c.signature}, 64'h1);
    chk("t1_pass", {63'd0, if_c.pass}, 64'd1);
    chk("t1_busy_off", {63'd0, if_c.busy}, 64'd0);
    chk("t1_x_quiet", {8'd0, x_c}, 64'd0);

    // two patterns: x = 1 then 2, signature 3, golden 4 fails
    if_c.pattern_count = 16'd2; if_c.golden = 23'h000004;
    if_c.start = 1'b1; tick(); if_c.start = 1'b0;
    chk("t2_x1", {8'd0, x_c}, 64'h1);
    chk("t2_sig_clr", {41'd0, if_c.signature}, 64'd0);
    chk("t2_pass_clr", {63'd0, if_c.pass}, 64'd0);
    tick();
    chk("t2_x2", {8'd0, x_c}, 64'h2);
    tick();
    chk("t2_done", {63'd0, if_c.done}, 64'd1);
    chk("t2_sig",  {41'd0, if_c.signature}, 64'h3);
    chk("t2_pass", {63'd0, if_c.pass}, 64'd0);
    if_c.golden = 23'h000003;
    tick();
    chk("t2_pass_live", {63'd0, if_c.pass}, 64'd1);

    // zero seed loads all-ones
    if_c.seed = 56'h0; if_c.pattern_count = 16'd1;
    if_c.start = 1'b1; tick(); if_c.start = 1'b0;
    chk("t3_x_ones", {8'd0, x_c}, 64'h00FF_FFFF_FFFF_FFFF);
    tick();
    chk("t3_done", {63'd0, if_c.done}, 64'd1);
    chk("t3_sig",  {41'd0, if_c.signature}, 64'h1);

    // zero patterns: straight to DONE with signature 0
    if_c.pattern_count = 16'd0; if_c.golden = 23'h0;
    if_c.start = 1'b1; tick(); if_c.start = 1'b0;
    chk("t4_done", {63'd0, if_c.done}, 64'd1);
    chk("t4_busy", {63'd0, if_c.busy}, 64'd0);
    chk("t4_sig",  {41'd0, if_c.signature}, 64'd0);
    chk("t4_pass", {63'd0, if_c.pass}, 64'd1);
    if_c.golden = 23'h000005;
    tick();
    chk("t4_pass_live", {63'd0, if_c.pass}, 64'd0);
    chk("t4_busy2", {63'd0, if_c.busy}, 64'd0);

    // 1000-pattern run on both latencies
    tie_one = 1'b0;
    seed5 = 56'h123456789ABCDE;
    exp5  = model_sig(seed5, 1000);
    if_c.seed = seed5; if_c.pattern_count = 16'd1000; if_c.golden = exp5;
    if_r.seed = seed5; if_r.pattern_count = 16'd1000; if_r.golden = exp5;
    if_c.start = 1'b1; if_r.start = 1'b1; tick();
    if_c.start = 1'b0; if_r.start = 1'b0;
    dc = 0; dr = 0; bc = 0; br = 0;
    for (int cyc = 1; cyc <= 1010; cyc++) begin
      if (cyc == 1) chk("t5_r_x1", {8'd0, x_r}, {8'd0, seed5});
      if (cyc == 1001) begin
        chk("t5_r_drain_busy", {63'd0, if_r.busy}, 64'd1);
        chk("t5_r_drain_x", {8'd0, x_r}, 64'd0);
      end
      if (if_c.done && dc == 0) dc = cyc;
      if (if_r.done && dr == 0) dr = cyc;
      if (if_c.busy) bc++;
      if (if_r.busy) br++;
      tick();
    end
    chk("t5_c_done_cyc", 64'(dc), 64'd1001);
    chk("t5_r_done_cyc", 64'(dr), 64'd1003);
    chk("t5_c_busy_cnt", 64'(bc), 64'd1000);
    chk("t5_r_busy_cnt", 64'(br), 64'd1002);
    chk("t5_c_sig", {41'd0, if_c.signature}, {41'd0, exp5});
    chk("t5_r_sig", {41'd0, if_r.signature}, {41'd0, exp5});
    chk("t5_c_pass", {63'd0, if_c.pass}, 64'd1);
    chk("t5_r_pass", {63'd0, if_r.pass}, 64'd1);

    seed6 = 56'hA5A50F0F123456;
    exp6  = model_sig(seed6, 100);
    if_c.seed = seed6; if_c.pattern_count = 16'd100; if_c.golden = exp6;

`ifdef PLA_BIST_ABORT_EN
    if_c.start = 1'b1; tick(); if_c.start = 1'b0;
    repeat (4) tick();
    chk("ab_pre_busy", {63'd0, if_c.busy}, 64'd1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ab_busy", {63'd0, if_c.busy}, 64'd0);
    chk("ab_done", {63'd0, if_c.done}, 64'd0);
    chk("ab_sig",  {41'd0, if_c.signature}, 64'd0);
    chk("ab_x",    {8'd0, x_c}, 64'd0);
`endif

    // reset asserted at cycle 5 of a 100-pattern run
    if_c.start = 1'b1; tick(); if_c.start = 1'b0;
    repeat (4) tick();
    chk("t6_pre_busy", {63'd0, if_c.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", {63'd0, if_c.busy}, 64'd0);
    chk("t6_done", {63'd0, if_c.done}, 64'd0);
    chk("t6_pass", {63'd0, if_c.pass}, 64'd0);
    chk("t6_sig",  {41'd0, if_c.signature}, 64'd0);
    chk("t6_x",    {8'd0, x_c}, 64'd0);
    #2 rst_n = 1'b1;
    tick();
    if_c.start = 1'b1; tick(); if_c.start = 1'b0;
    dc = 0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (if_c.done && dc == 0) dc = cyc;
      tick();
    end
    chk("t6_done_cyc", 64'(dc), 64'd101);
    chk("t6_sig_rerun", {41'd0, if_c.signature}, {41'd0, exp6});
    chk("t6_pass_rerun", {63'd0, if_c.pass}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
